// File: rtl/link_speed_detect_mp.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// link_speed_detect_mp
//
// Multi-port RGMII link speed detector. Each port delivers a toggle that flips
// every 4 rx_clk cycles, generated in its own RX domain. Each toggle is brought
// into sys_clk and its transitions are counted over a shared window of
// 2^WIN_LOG2 sys_clk cycles. The count is classified as none/10M/100M/1000M,
// and each classification is debounced before it reaches the outputs.
//
// Ports:
//   sys_clk      in   system clock (125 MHz)
//   sys_rst_n    in   asynchronous active-low reset
//   enable       in   1 = run measurement windows back to back
//   rx_tgl       in   [NUM_PORTS]     per-port rx_clk/8 toggle (asynchronous)
//   speed        out  [2*NUM_PORTS]   port i at [2i+1:2i]:
//                                     00 none, 01 10M, 10 100M, 11 1000M
//   speed_valid  out  [NUM_PORTS]     port has a debounced result
//   speed_chg    out  [NUM_PORTS]     1-cycle pulse when a port's code changes
//   meas_done    out                  1-cycle pulse during each EVAL cycle
//   raw_cnt      out  [NUM_PORTS*WIN_LOG2]  only with LINK_SPEED_RAW_CNT_EN:
//                                     saturated edge count of the last window
//
// Optional feature macro: LINK_SPEED_RAW_CNT_EN (adds raw_cnt).
//
// Handshake: there is no valid/ready pair. meas_done is a strobe that is high
// for exactly the EVAL cycle. speed, speed_valid and speed_chg take their new
// values on the clock edge that ends EVAL, so any speed_chg pulse appears in
// the cycle after meas_done.
// -----------------------------------------------------------------------------
module link_speed_detect_mp #(
    parameter int NUM_PORTS = 4,
    parameter int WIN_LOG2  = 10,
    parameter int TH_1G     = 64,
    parameter int TH_100M   = 8,
    parameter int STABLE_N  = 3
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   enable,
    input  logic [NUM_PORTS-1:0]   rx_tgl,
    output logic [2*NUM_PORTS-1:0] speed,
    output logic [NUM_PORTS-1:0]   speed_valid,
    output logic [NUM_PORTS-1:0]   speed_chg,
    output logic                   meas_done
`ifdef LINK_SPEED_RAW_CNT_EN
    ,
    output logic [NUM_PORTS*WIN_LOG2-1:0] raw_cnt
`endif
);

    localparam logic [WIN_LOG2-1:0] TH_1G_C   = WIN_LOG2'(TH_1G);
    localparam logic [WIN_LOG2-1:0] TH_100M_C = WIN_LOG2'(TH_100M);
    localparam logic [3:0]          STABLE_C  = 4'(STABLE_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        EVAL    = 2'd2
    } state_t;

    // state is the observable FSM state for checkers
    state_t state;
    state_t state_nx;

    logic [WIN_LOG2-1:0]                 win_tmr;
    logic                                win_last;
    logic [NUM_PORTS-1:0]                sync1;
    logic [NUM_PORTS-1:0]                sync2;
    logic [NUM_PORTS-1:0]                sync3;
    logic [NUM_PORTS-1:0]                edge_det;
    logic [NUM_PORTS-1:0][WIN_LOG2-1:0]  edge_cnt;

    logic [NUM_PORTS-1:0][1:0]           cand_code;
    logic [NUM_PORTS-1:0][3:0]           stab_cnt;
    logic [NUM_PORTS-1:0][1:0]           cls;
    logic [NUM_PORTS-1:0][1:0]           cand_nx;
    logic [NUM_PORTS-1:0][3:0]           stab_nx;
    logic [NUM_PORTS-1:0]                upd;
    logic [NUM_PORTS-1:0]                chg_nx;

    function automatic logic [1:0] classify(input logic [WIN_LOG2-1:0] c);
        logic [1:0] code;
        if (c >= TH_1G_C)        code = 2'b11;
        else if (c >= TH_100M_C) code = 2'b10;
        else if (c != '0)        code = 2'b01;
        else                     code = 2'b00;
        return code;
    endfunction

    // ---------------- FSM ----------------
    assign win_last = &win_tmr;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable)   state_nx = MEASURE;
            MEASURE: if (win_last) state_nx = EVAL;
            EVAL:    state_nx = enable ? MEASURE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign meas_done = (state == EVAL);

    // ---------------- synchroniser and edge detect ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= rx_tgl;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Both directions of the toggle count as an edge.
    assign edge_det = sync2 ^ sync3;

    // ---------------- window timer and edge counters ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            win_tmr  <= '0;
            edge_cnt <= '0;
        end else begin
            case (state)
                MEASURE: begin
                    win_tmr <= win_tmr + 1'b1;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (edge_det[i] && !(&edge_cnt[i]))
                            edge_cnt[i] <= edge_cnt[i] + 1'b1;
                    end
                end
                EVAL: begin
                    win_tmr <= '0;
                    // An edge seen while evaluating opens the next window's count.
                    for (int i = 0; i < NUM_PORTS; i++)
                        edge_cnt[i] <= WIN_LOG2'(edge_det[i]);
                end
                default: begin
                    win_tmr  <= '0;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

    // ---------------- classification and debounce ----------------
    always_comb begin
        cls     = '0;
        cand_nx = '0;
        stab_nx = '0;
        upd     = '0;
        chg_nx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cls[i] = classify(edge_cnt[i]);
            if (cls[i] == cand_code[i]) begin
                cand_nx[i] = cand_code[i];
                stab_nx[i] = (stab_cnt[i] >= STABLE_C) ? STABLE_C : stab_cnt[i] + 4'd1;
            end else begin
                cand_nx[i] = cls[i];
                stab_nx[i] = 4'd1;
            end
            // First stable result is published even if it equals the default code.
            upd[i]    = (stab_nx[i] == STABLE_C) &&
                        ((cand_nx[i] != speed[2*i +: 2]) || !speed_valid[i]);
            chg_nx[i] = upd[i] && (cand_nx[i] != speed[2*i +: 2]);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            speed       <= '1;
            speed_valid <= '0;
            speed_chg   <= '0;
            cand_code   <= '0;
            stab_cnt    <= '0;
        end else begin
            speed_chg <= '0;
            if (state == EVAL) begin
                cand_code <= cand_nx;
                stab_cnt  <= stab_nx;
                speed_chg <= chg_nx;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (upd[i]) begin
                        speed[2*i +: 2] <= cand_nx[i];
                        speed_valid[i]  <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef LINK_SPEED_RAW_CNT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)          raw_cnt <= '0;
        else if (state == EVAL)  raw_cnt <= edge_cnt;
    end
`endif

endmodule

// File: tb/tb_link_speed_detect_mp.sv
`timescale 1ns/1ps
module tb_link_speed_detect_mp;

  localparam int NP = 4;
  localparam int NW = 20;

  // ---------------- clock / reset ----------------
  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          enable;
  logic [NP-1:0] rx_tgl;
  logic [2*NP-1:0] speed;
  logic [NP-1:0] speed_valid;
  logic [NP-1:0] speed_chg;
  logic          meas_done;
`ifdef LINK_SPEED_RAW_CNT_EN
  logic [NP*10-1:0] raw_cnt;
`endif

  always #4 sys_clk = ~sys_clk;

  link_speed_detect_mp dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .enable      (enable),
    .rx_tgl      (rx_tgl),
    .speed       (speed),
    .speed_valid (speed_valid),
    .speed_chg   (speed_chg),
    .meas_done   (meas_done)
`ifdef LINK_SPEED_RAW_CNT_EN
    ,
    .raw_cnt     (raw_cnt)
`endif
  );

  // ---------------- shared state ----------------
  int tests = 0;
  int fails = 0;
  int spurious_chg = 0;
  int mon_win = 0;
  logic [15:0] exp_q[$];   // {speed[7:0], speed_valid[3:0], speed_chg[3:0]}

  // toggle generator configuration: period 0 = hold, limit -1 = unlimited
  int cfg_per[NP];
  int cfg_lim[NP];
  int cfg_seq = 0;

  // per-window directed vectors for port 0 (ports 1..3 fixed: 100M, 10M, none)
  int t_per[NW] = '{4, 4, 4, 20, 4, 20, 4, 20, 20, 20,
                    4, 4, 4, 4, 4, 4, 1, 1, 1, 4};
  int t_lim[NW] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1,
                    64, 64, 64, 63, 63, 63, -1, -1, -1, -1};
  logic [15:0] t_exp[NW] = '{16'hFF00, 16'hFF00, 16'h1BFE, 16'h1BF0, 16'h1BF0,
                             16'h1BF0, 16'h1BF0, 16'h1BF0, 16'h1BF0, 16'h1AF1,
                             16'h1AF0, 16'h1AF0, 16'h1BF1, 16'h1BF0, 16'h1BF0,
                             16'h1AF1, 16'h1AF0, 16'h1AF0, 16'h1BF1, 16'h1BF0};
  int t_raw[NW] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1,
                    -1, 64, 64, 63, 63, 63, -1, 1023, 1023, -1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- toggle generator (drives rx_tgl) ----------------
  initial begin
    int seen;
    int ph[NP];
    int left[NP];
    seen = 0;
    rx_tgl = '0;
    for (int p = 0; p < NP; p++) begin
      ph[p] = 0;
      left[p] = 0;
    end
    forever begin
      @(posedge sys_clk);
      #1;
      if (seen != cfg_seq) begin
        seen = cfg_seq;
        for (int p = 0; p < NP; p++) begin
          ph[p] = 0;
          left[p] = cfg_lim[p];
        end
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (cfg_per[p] > 0 && left[p] != 0) begin
            ph[p]++;
            if (ph[p] >= cfg_per[p]) begin
              ph[p] = 0;
              rx_tgl[p] = ~rx_tgl[p];
              if (left[p] > 0) left[p]--;
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_window(input int per0, input int lim0, input logic [15:0] e);
    cfg_per[0] = per0;
    cfg_lim[0] = lim0;
    cfg_seq++;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!meas_done && n < 3000);
    if (!meas_done) begin
      tests++;
      fails++;
      $display("FAIL meas_done_timeout: got no pulse in %0d cycles, expected one", n);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge sys_clk);
      if (meas_done) begin
        mon_win++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_meas_done: got pulse %0d, expected none", mon_win);
        end else begin
          e = exp_q.pop_front();
          @(negedge sys_clk);
          check($sformatf("window%0d", mon_win), {16'h0, speed, speed_valid, speed_chg}, {16'h0, e});
        end
      end else if (speed_chg != '0) begin
        spurious_chg++;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int n_done;
    sys_rst_n = 1'b0;
    enable = 1'b0;
    for (int p = 0; p < NP; p++) begin
      cfg_per[p] = 0;
      cfg_lim[p] = -1;
    end
    repeat (5) @(negedge sys_clk);
    check("reset_outputs", {16'h0, speed, speed_valid, speed_chg}, 32'hFF00);
    check("reset_meas_done", {31'h0, meas_done}, 32'h0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("idle_no_done", {31'h0, meas_done}, 32'h0);

    cfg_per[1] = 20;
    cfg_per[2] = 200;
    cfg_per[3] = 0;

    for (int w = 0; w < NW; w++) begin
      start_window(t_per[w], t_lim[w], t_exp[w]);
      if (w == 0) enable = 1'b1;
      if (w == NW - 1) begin
        repeat (500) @(negedge sys_clk);
        enable = 1'b0;
      end
      wait_done(n);
      if (w == 1 || w == 2) check($sformatf("period_w%0d", w + 1), n, 1025);
`ifdef LINK_SPEED_RAW_CNT_EN
      if (t_raw[w] >= 0) begin
        @(negedge sys_clk);
        check($sformatf("raw_cnt_w%0d", w + 1), {22'h0, raw_cnt[9:0]}, t_raw[w]);
        check($sformatf("raw_cnt_p3_w%0d", w + 1), {22'h0, raw_cnt[39:30]}, 32'h0);
      end
`endif
    end

    // enable dropped: no further windows, outputs held
    n_done = 0;
    repeat (3000) begin
      @(negedge sys_clk);
      if (meas_done) n_done++;
    end
    check("idle_after_disable", n_done, 0);
    check("held_outputs", {16'h0, speed, speed_valid, speed_chg}, 32'h1BF0);

    // reset in the middle of a window
    cfg_per[0] = 4;
    cfg_lim[0] = -1;
    cfg_seq++;
    enable = 1'b1;
    repeat (300) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("midwin_reset_outputs", {16'h0, speed, speed_valid, speed_chg}, 32'hFF00);
    check("midwin_reset_done", {31'h0, meas_done}, 32'h0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    exp_q.push_back(16'hFF00);
    wait_done(n);
    check("post_reset_window_len", n, 1025);
    start_window(4, -1, 16'hFF00);
    wait_done(n);
    start_window(4, -1, 16'h1BFE);
    wait_done(n);
    repeat (3) @(negedge sys_clk);

    check("queue_drained", exp_q.size(), 0);
    check("no_spurious_chg", spurious_chg, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
